// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: digit-serial unsigned a_in-b_in-Bin with valid/ready handshakes; define SUB_OVERFLOW_EN to compile in the signed overflow flag
module digit_serial_subtractor #(
  parameter int Nbits = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Nbits-1:0] a_in,
  input  logic [Nbits-1:0] b_in,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] diff,
  output logic             Bout,
  output logic             ovf
);
  localparam int NDIG = Nbits / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [Nbits-1:0] a_sh, b_sh, work, work_nxt;
  logic [DIGIT-1:0] d;
  logic [CW-1:0] cnt;
  logic brw, nb, accept, last;
  if (Nbits % DIGIT != 0) begin : g_bad_digit
    $error("Nbits must be a multiple of DIGIT");
  end
  assign {nb, d} = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
  assign work_nxt = Nbits'({d, work} >> DIGIT);
  assign accept = state == IDLE && in_valid;
  assign last = state == RUN && cnt == CW'(NDIG - 1);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next-state decode
  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                (out_ready ? IDLE : DONE);
  // handshake outputs decoded from state only
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // operand shifters, borrow chain and result registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      work <= '0;
      brw <= 1'b0;
      cnt <= '0;
      diff <= '0;
      Bout <= 1'b0;
    end else if (accept) begin
      a_sh <= a_in;
      b_sh <= b_in;
      brw <= Bin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      work <= work_nxt;
      brw <= nb;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= work_nxt;
        Bout <= nb;
      end
    end
`ifdef SUB_OVERFLOW_EN
  logic a_msb, b_msb;
  // operand signs captured at acceptance feed the overflow flag on completion
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_msb <= a_in[Nbits-1];
      b_msb <= b_in[Nbits-1];
    end else if (last)
      ovf <= a_msb != b_msb && work_nxt[Nbits-1] != a_msb;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor: directed checks of the digit-serial subtractor
module tb_digit_serial_subtractor;
`ifdef SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, Bin = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, diff;
  logic in_ready, out_valid, Bout, ovf;
  int checks = 0, errors = 0;

  digit_serial_subtractor dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .Bin(Bin), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .Bout(Bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic bi);
    a_in = a;
    b_in = b;
    Bin = bi;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a_in = 16'hDEAD;
    b_in = 16'hBEEF;
    Bin = 1'b1;
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                    input logic [15:0] ed, input logic eb, input logic eo, input bit ack);
    start(a, b, bi);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("%s_out_valid_E%0d", tag, i), out_valid, i == 4);
      check($sformatf("%s_in_ready_E%0d", tag, i), in_ready, 0);
    end
    check({tag, "_diff"}, diff, ed);
    check({tag, "_Bout"}, Bout, eb);
    check({tag, "_ovf"}, ovf, eo & OVF_EN);
    if (ack) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_in_ready_after_ack"}, in_ready, 1);
      check({tag, "_out_valid_after_ack"}, out_valid, 0);
      check({tag, "_diff_held"}, diff, ed);
    end
  endtask

  initial begin
    #2;
    check("rst_diff", diff, 16'h0000);
    check("rst_Bout", Bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    op("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    op("sovf_clr", 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    op("binborrow", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    in_valid = 1'b1;
    a_in = 16'h0100;
    b_in = 16'h0001;
    Bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, 16'hFFFF);
      check("hold_Bout", Bout, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_diff", diff, 16'hFFFF);
    op("next", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);

    start(16'hFFFF, 16'h0001, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 16'h0000);
    check("abort_Bout", Bout, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_out_valid", out_valid, 0);
      check("abort_idle", in_ready, 1);
    end
    op("after_abort", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
